ccff_chain_loader: RTL and testbench

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_chain_loader.sv | 184 ++++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams a byte-wide bitstream into a serial
// configuration flip-flop chain, MSB of each byte first, and keeps the
// fabric isolated (isol_n=0) until a load has completed cleanly.
//
// Optional feature: define CCFF_TAIL_CHECK_EN to prepend an 8-bit header
// (0xA5) to every load and verify it emerging from ccff_tail during the
// last 8 shifts. Without the macro there is no header, no comparator and
// error is tied low.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 1024
) (
    input  logic       prog_clk,
    input  logic       prog_reset_n,
    input  logic       start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       ccff_head,
    output logic       ccff_shift_en,
    input  logic       ccff_tail,
    output logic       isol_n,
    output logic       busy,
    output logic       done,
    output logic       error
);

`ifdef CCFF_TAIL_CHECK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, HDR = 2'd3} state_t;
    localparam logic [7:0]  HEADER       = 8'hA5;
    localparam logic [15:0] CHAIN_LEN16  = 16'(CHAIN_LEN);
    localparam logic [15:0] TOTAL_SHIFTS = 16'(CHAIN_LEN + 8);
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2} state_t;
    localparam logic [15:0] TOTAL_SHIFTS = 16'(CHAIN_LEN);
`endif

    state_t      state;
    logic [15:0] shift_cnt;   // shifts issued so far in this load
    logic [2:0]  bit_idx;     // position within the current byte
    logic [6:0]  shreg;       // remaining bits of the current byte, next bit at [6]
    logic        shifting;
    logic        accept;
    logic        last_bit;
    logic        final_shift;
    logic        err_next;

`ifdef CCFF_TAIL_CHECK_EN
    assign shifting = (state == SHIFT) || (state == HDR);
`else
    assign shifting = (state == SHIFT);
`endif

    assign accept      = (state == LOAD) && s_valid && s_ready;
    assign last_bit    = (bit_idx == 3'd7);
    // The header is always followed by data, so only SHIFT can end a load.
    assign final_shift = (state == SHIFT) && last_bit && (shift_cnt + 16'd1 == TOTAL_SHIFTS);

`ifdef CCFF_TAIL_CHECK_EN
    logic       tail_window;
    logic       tail_bad;
    logic [2:0] hdr_pos;
    logic       err_acc;
    logic       err_q;

    // The header reaches the tail during the last 8 shifts. CHAIN_LEN is a
    // multiple of 8, so the header bit offset is just the low counter bits.
    assign tail_window = (state == SHIFT) && (shift_cnt >= CHAIN_LEN16);
    assign hdr_pos     = 3'd7 - shift_cnt[2:0];
    assign tail_bad    = tail_window && (ccff_tail != HEADER[hdr_pos]);
    assign err_next    = err_acc | tail_bad;
    assign error       = err_q;

    // Accumulate tail mismatches over a load; publish the verdict at completion.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            err_acc <= 1'b0;
            err_q   <= 1'b0;
        end else if (state == IDLE && start) begin
            err_acc <= 1'b0;
            err_q   <= 1'b0;
        end else if (shifting) begin
            err_acc <= err_next;
            if (final_shift) begin
                err_q <= err_next;
            end
        end
    end
`else
    logic unused_tail;

    assign unused_tail = ccff_tail;
    assign err_next    = 1'b0;
    assign error       = 1'b0;
`endif

    // Load sequencer: state, counters and all registered handshake/chain outputs.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state         <= IDLE;
            shift_cnt     <= '0;
            bit_idx       <= '0;
            s_ready       <= 1'b0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            isol_n        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        isol_n    <= 1'b0;
                        shift_cnt <= '0;
                        bit_idx   <= '0;
`ifdef CCFF_TAIL_CHECK_EN
                        state         <= HDR;
                        ccff_shift_en <= 1'b1;
                        ccff_head     <= HEADER[7];
`else
                        state   <= LOAD;
                        s_ready <= 1'b1;
`endif
                    end
                end
                LOAD: begin
                    if (accept) begin
                        state         <= SHIFT;
                        s_ready       <= 1'b0;
                        ccff_shift_en <= 1'b1;
                        ccff_head     <= s_data[7];
                        bit_idx       <= '0;
                    end
                end
`ifdef CCFF_TAIL_CHECK_EN
                HDR,
`endif
                SHIFT: begin
                    shift_cnt <= shift_cnt + 16'd1;
                    bit_idx   <= bit_idx + 3'd1;
                    if (last_bit) begin
                        ccff_shift_en <= 1'b0;
                        ccff_head     <= 1'b0;
                        if (final_shift) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            isol_n <= ~err_next;
                        end else begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                        end
                    end else begin
                        ccff_head <= shreg[6];
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Byte shifter: data path only, so it carries no reset.
    always_ff @(posedge prog_clk) begin
`ifdef CCFF_TAIL_CHECK_EN
        if (state == IDLE && start) begin
            shreg <= HEADER[6:0];
        end else if (accept) begin
            shreg <= s_data[6:0];
        end else if (shifting) begin
            shreg <= {shreg[5:0], 1'b0};
        end
`else
        if (accept) begin
            shreg <= s_data[6:0];
        end else if (shifting) begin
            shreg <= {shreg[5:0], 1'b0};
        end
`endif
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Testbench for ccff_chain_loader with a 16-bit chain model.
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 16;
`ifdef CCFF_TAIL_CHECK_EN
    localparam int HDR_CYC = 8;
`else
    localparam int HDR_CYC = 0;
`endif

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          g0;
        int          g1;
        bit          poke;
        logic [15:0] exp_chain;
        int          exp_cyc;
    } vec_t;

    logic        prog_clk = 1'b0;
    logic        prog_reset_n;
    logic        start;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        ccff_head;
    logic        ccff_shift_en;
    logic        ccff_tail;
    logic        isol_n;
    logic        busy;
    logic        done;
    logic        error;

    logic [CHAIN_LEN-1:0] chain = '0;
    bit          tail_stuck0 = 1'b0;
    int          en_cnt = 0;
    int          viol = 0;
    int          checks = 0;
    int          failures = 0;

    ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN)) dut (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .start         (start),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .isol_n        (isol_n),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 prog_clk = ~prog_clk;

    assign ccff_tail = tail_stuck0 ? 1'b0 : chain[CHAIN_LEN-1];

    // Chain model plus per-cycle protocol invariants.
    always @(posedge prog_clk) begin
        if (ccff_shift_en) begin
            chain  <= {chain[CHAIN_LEN-2:0], ccff_head};
            en_cnt <= en_cnt + 1;
        end
        if ((!ccff_shift_en && ccff_head) || (s_ready && ccff_shift_en) ||
            (!busy && (s_ready || ccff_shift_en)))
            viol <= viol + 1;
    end

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_s_ready"}, s_ready, 0);
        chk({nm, "_head"}, ccff_head, 0);
        chk({nm, "_shift_en"}, ccff_shift_en, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_error"}, error, 0);
        chk({nm, "_isol_n"}, isol_n, 0);
    endtask

    // One full two-byte load; g0/g1 are LOAD cycles with s_valid withheld
    // before each byte; poke raises start mid-load and on the final shift.
    task automatic run_load(input string nm, input logic [7:0] b0, input logic [7:0] b1,
                            input int g0, input int g1, input bit poke,
                            input logic [15:0] exp_chain, input int exp_cyc, input bit exp_err);
        int cyc;
        int sent;
        int gl[2];
        int base;
        int done_cyc;
        bit hs;
        gl[0] = g0;
        gl[1] = g1;
        sent = 0;
        done_cyc = -1;
        @(negedge prog_clk);
        base = en_cnt;
        start = 1'b1;
        s_valid = 1'b0;
        @(posedge prog_clk);
        cyc = 1;
        while (done_cyc < 0 && cyc < 300) begin
            @(negedge prog_clk);
            if (cyc == 2) begin
                chk({nm, "_busy_during"}, busy, 1);
                chk({nm, "_isol_during"}, isol_n, 0);
            end
            if (done) begin
                done_cyc = cyc;
            end else begin
                start = poke && (cyc == 3 || cyc == exp_cyc - 1);
                s_valid = 1'b0;
                if (sent < 2) begin
                    if (gl[sent] > 0 && s_ready) begin
                        gl[sent]--;
                    end else begin
                        s_valid = 1'b1;
                        s_data = (sent == 0) ? b0 : b1;
                    end
                end
                hs = s_valid && s_ready;
                @(posedge prog_clk);
                cyc++;
                if (hs) sent++;
            end
        end
        start = 1'b0;
        s_valid = 1'b0;
        chk({nm, "_done_cycle"}, done_cyc, exp_cyc);
        chk({nm, "_busy_end"}, busy, 0);
        chk({nm, "_error"}, error, exp_err);
        chk({nm, "_isol_n"}, isol_n, !exp_err);
        chk({nm, "_chain"}, chain, exp_chain);
        chk({nm, "_enables"}, en_cnt - base, 16 + HDR_CYC);
        repeat (3) @(negedge prog_clk);
        chk({nm, "_done_held"}, done, 1);
        chk({nm, "_no_restart"}, busy, 0);
    endtask

    task automatic run_reset_midload();
        int base;
        int k;
        @(negedge prog_clk);
        base = en_cnt;
        start = 1'b1;
        s_valid = 1'b0;
        @(posedge prog_clk);
        @(negedge prog_clk);
        start = 1'b0;
        k = 0;
        while ((en_cnt - base) < 5 + HDR_CYC && k < 100) begin
            s_valid = 1'b1;
            s_data = 8'h3C;
            @(posedge prog_clk);
            @(negedge prog_clk);
            k++;
        end
        chk("rst_shift_count", en_cnt - base, 5 + HDR_CYC);
        chk("rst_busy_before", busy, 1);
        chk("rst_shift_en_before", ccff_shift_en, 1);
        #1 prog_reset_n = 1'b0;
        #1 chk_idle_outputs("rst_async");
        s_valid = 1'b0;
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        @(negedge prog_clk);
        chk_idle_outputs("rst_after_release");
        run_load("after_rst", 8'h3C, 8'hF0, 0, 0, 1'b0, 16'h3CF0, 19 + HDR_CYC, 1'b0);
    endtask

    vec_t tbl[5];

    initial begin
        logic [7:0] rb0;
        logic [7:0] rb1;
        int rg0;
        int rg1;
        bit rpoke;

        tbl[0] = '{8'h3C, 8'hF0, 0, 0, 1'b0, 16'h3CF0, 19};
        tbl[1] = '{8'h3C, 8'hF0, 0, 5, 1'b0, 16'h3CF0, 24};
        tbl[2] = '{8'h00, 8'hFF, 0, 0, 1'b0, 16'h00FF, 19};
        tbl[3] = '{8'hFF, 8'h00, 2, 0, 1'b1, 16'hFF00, 21};
        tbl[4] = '{8'hA5, 8'h5A, 1, 3, 1'b1, 16'hA55A, 23};

        prog_reset_n = 1'b0;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = 8'h00;
        repeat (2) @(negedge prog_clk);
        chk_idle_outputs("reset");
        prog_reset_n = 1'b1;
        @(negedge prog_clk);
        chk_idle_outputs("idle");

        for (int i = 0; i < 5; i++) begin
            run_load($sformatf("vec%0d", i), tbl[i].b0, tbl[i].b1, tbl[i].g0, tbl[i].g1,
                     tbl[i].poke, tbl[i].exp_chain, tbl[i].exp_cyc + HDR_CYC, 1'b0);
        end

        // Random loads: the chain holds the last 16 bits streamed, and each
        // byte costs 9 cycles plus any withheld-valid cycles.
        for (int i = 0; i < 6; i++) begin
            rb0 = 8'($urandom);
            rb1 = 8'($urandom);
            rg0 = int'($urandom_range(0, 3));
            rg1 = int'($urandom_range(0, 3));
            rpoke = 1'($urandom_range(0, 1));
            run_load($sformatf("rnd%0d", i), rb0, rb1, rg0, rg1, rpoke,
                     {rb0, rb1}, 1 + HDR_CYC + 9 * 2 + rg0 + rg1, 1'b0);
        end

        run_reset_midload();

`ifdef CCFF_TAIL_CHECK_EN
        tail_stuck0 = 1'b1;
        run_load("tail_stuck", 8'h12, 8'h34, 0, 0, 1'b0, 16'h1234, 27, 1'b1);
        tail_stuck0 = 1'b0;
        run_load("tail_good", 8'h12, 8'h34, 0, 0, 1'b0, 16'h1234, 27, 1'b0);
`endif

        chk("protocol_invariants", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
